// File: rtl/id_ex_forward_pkg.sv
// Shared definitions for the ID/EX pipeline register, its forwarding logic and the ALU.
// Forward select codes, ALU op codes and the ID/EX register layout live here.
package id_ex_forward_pkg;

    typedef enum logic [2:0] {
        FWD_NONE = 3'b000,
        FWD_MEM  = 3'b001,
        FWD_EX   = 3'b010
    } fwd_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        uses_rs;
        logic        uses_rt;
        logic [2:0]  alu_ctrl;
        logic        alu_src;
        logic        reg_dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/id_ex_forward_fwd.sv
// Combinational forward select for one ALU operand source register.
// EX/MEM wins over MEM/WB; register 0 and unused or blocked operands never forward.
module forward_unit
    import id_ex_forward_pkg::*;
(
    input  logic       i_uses,
    input  logic       i_block,
    input  logic [4:0] i_src,
    input  logic       i_ex_wr,
    input  logic [4:0] i_ex_rd,
    input  logic       i_mem_wr,
    input  logic [4:0] i_mem_rd,
    output fwd_e       o_sel
);

    always_comb begin
        o_sel = FWD_NONE;
        if (i_uses && !i_block && (i_src != 5'd0)) begin
            if (i_ex_wr && (i_ex_rd == i_src)) begin
                o_sel = FWD_EX;
            end else if (i_mem_wr && (i_mem_rd == i_src)) begin
                o_sel = FWD_MEM;
            end
        end
    end

endmodule

// File: rtl/id_ex_forward.sv
// ID/EX pipeline register with operand forwarding selects, load-use stall detection
// and a saturating count of inserted bubbles.
module id_ex_forward
    import id_ex_forward_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] RsData_i,
    input  logic [31:0] RtData_i,
    input  logic [31:0] Imm_i,
    input  logic [4:0]  Rs_i,
    input  logic [4:0]  Rt_i,
    input  logic [4:0]  Rd_i,
    input  logic        UsesRs_i,
    input  logic        UsesRt_i,
    input  logic [2:0]  ALUCtrl_i,
    input  logic        ALUSrc_i,
    input  logic        RegDst_i,
    input  logic        RegWrite_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        MemtoReg_i,
    input  logic        Flush_i,
    input  logic        ExRegWrite_i,
    input  logic [4:0]  ExRd_i,
    input  logic        MemRegWrite_i,
    input  logic [4:0]  MemRd_i,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o,
    output logic [2:0]  ALUCtrl_o,
    output logic [2:0]  ForwardRs_o,
    output logic [2:0]  ForwardRt_o,
    output logic [31:0] StoreData_o,
    output logic [4:0]  WriteReg_o,
    output logic        RegWrite_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic        MemtoReg_o,
    output logic        Stall_o,
    output logic [15:0] BubbleCnt_o
);

    id_ex_t      r_id_ex;
    logic [15:0] r_bubble_cnt;
    id_ex_t      w_id_next;
    logic [4:0]  w_write_reg;
    logic        w_stall;
    fwd_e        w_fwd_rs;
    fwd_e        w_fwd_rt;

    always_comb begin
        w_id_next            = ID_EX_BUBBLE;
        w_id_next.rs_data    = RsData_i;
        w_id_next.rt_data    = RtData_i;
        w_id_next.imm        = Imm_i;
        w_id_next.rs         = Rs_i;
        w_id_next.rt         = Rt_i;
        w_id_next.rd         = Rd_i;
        w_id_next.uses_rs    = UsesRs_i;
        w_id_next.uses_rt    = UsesRt_i;
        w_id_next.alu_ctrl   = ALUCtrl_i;
        w_id_next.alu_src    = ALUSrc_i;
        w_id_next.reg_dst    = RegDst_i;
        w_id_next.reg_write  = RegWrite_i;
        w_id_next.mem_read   = MemRead_i;
        w_id_next.mem_write  = MemWrite_i;
        w_id_next.mem_to_reg = MemtoReg_i;
    end

    assign w_write_reg = r_id_ex.reg_dst ? r_id_ex.rd : r_id_ex.rt;

    // Load-use hazard: the load in EX cannot supply ID's operand in time.
    assign w_stall = r_id_ex.mem_read && (w_write_reg != 5'd0) &&
                     ((UsesRs_i && (Rs_i == w_write_reg)) ||
                      (UsesRt_i && (Rt_i == w_write_reg)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_id_ex      <= ID_EX_BUBBLE;
            r_bubble_cnt <= 16'd0;
        end else if (w_stall || Flush_i) begin
            r_id_ex      <= ID_EX_BUBBLE;
            r_bubble_cnt <= sat_inc16(r_bubble_cnt);
        end else begin
            r_id_ex      <= w_id_next;
        end
    end

    forward_unit u_fwd_rs (
        .i_uses   (r_id_ex.uses_rs),
        .i_block  (1'b0),
        .i_src    (r_id_ex.rs),
        .i_ex_wr  (ExRegWrite_i),
        .i_ex_rd  (ExRd_i),
        .i_mem_wr (MemRegWrite_i),
        .i_mem_rd (MemRd_i),
        .o_sel    (w_fwd_rs)
    );

    // An immediate operand replaces Rt on the ALU input, so Rt is never forwarded then.
    forward_unit u_fwd_rt (
        .i_uses   (r_id_ex.uses_rt),
        .i_block  (r_id_ex.alu_src),
        .i_src    (r_id_ex.rt),
        .i_ex_wr  (ExRegWrite_i),
        .i_ex_rd  (ExRd_i),
        .i_mem_wr (MemRegWrite_i),
        .i_mem_rd (MemRd_i),
        .o_sel    (w_fwd_rt)
    );

    assign data1_o     = r_id_ex.rs_data;
    assign data2_o     = r_id_ex.alu_src ? r_id_ex.imm : r_id_ex.rt_data;
    assign ALUCtrl_o   = r_id_ex.alu_ctrl;
    assign ForwardRs_o = w_fwd_rs;
    assign ForwardRt_o = w_fwd_rt;
    assign StoreData_o = r_id_ex.rt_data;
    assign WriteReg_o  = w_write_reg;
    assign RegWrite_o  = r_id_ex.reg_write;
    assign MemRead_o   = r_id_ex.mem_read;
    assign MemWrite_o  = r_id_ex.mem_write;
    assign MemtoReg_o  = r_id_ex.mem_to_reg;
    assign Stall_o     = w_stall;
    assign BubbleCnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_forward.sv
// Scoreboard bench for id_ex_forward: driver pushes expected outputs from an
// instruction-level model, a negedge monitor pops and compares every cycle.
module tb_id_ex_forward;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        uses_rs;
        logic        uses_rt;
        logic [2:0]  alu;
        logic        alu_src;
        logic        reg_dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        ex_wr;
        logic [4:0]  ex_rd;
        logic        mem_wr;
        logic [4:0]  mem_rd;
    } stim_t;

    typedef struct packed {
        logic [31:0] data1;
        logic [31:0] data2;
        logic [2:0]  alu;
        logic [2:0]  fwd_rs;
        logic [2:0]  fwd_rt;
        logic [31:0] store;
        logic [4:0]  wreg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        stall;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] RsData_i, RtData_i, Imm_i;
    logic [4:0]  Rs_i, Rt_i, Rd_i, ExRd_i, MemRd_i;
    logic        UsesRs_i, UsesRt_i, ALUSrc_i, RegDst_i, RegWrite_i;
    logic        MemRead_i, MemWrite_i, MemtoReg_i, Flush_i, ExRegWrite_i, MemRegWrite_i;
    logic [2:0]  ALUCtrl_i;
    logic [31:0] data1_o, data2_o, StoreData_o;
    logic [2:0]  ALUCtrl_o, ForwardRs_o, ForwardRt_o;
    logic [4:0]  WriteReg_o;
    logic        RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, Stall_o;
    logic [15:0] BubbleCnt_o;

    always #5 clk = ~clk;

    id_ex_forward dut (
        .clk_i(clk), .rst_i(rst_i),
        .RsData_i(RsData_i), .RtData_i(RtData_i), .Imm_i(Imm_i),
        .Rs_i(Rs_i), .Rt_i(Rt_i), .Rd_i(Rd_i),
        .UsesRs_i(UsesRs_i), .UsesRt_i(UsesRt_i), .ALUCtrl_i(ALUCtrl_i),
        .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .RegWrite_i(RegWrite_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .MemtoReg_i(MemtoReg_i),
        .Flush_i(Flush_i),
        .ExRegWrite_i(ExRegWrite_i), .ExRd_i(ExRd_i),
        .MemRegWrite_i(MemRegWrite_i), .MemRd_i(MemRd_i),
        .data1_o(data1_o), .data2_o(data2_o), .ALUCtrl_o(ALUCtrl_o),
        .ForwardRs_o(ForwardRs_o), .ForwardRt_o(ForwardRt_o),
        .StoreData_o(StoreData_o), .WriteReg_o(WriteReg_o),
        .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o),
        .Stall_o(Stall_o), .BubbleCnt_o(BubbleCnt_o)
    );

    // Reference model: the instruction currently sitting in EX, plus the bubble tally.
    stim_t  in_ex;
    stim_t  cur;
    int     bubbles;
    exp_t   sb_q[$];
    int     errors = 0;
    int     checks = 0;
    int     cycle  = 0;

    function automatic logic [4:0] dest_of(input stim_t s);
        return s.reg_dst ? s.rd : s.rt;
    endfunction

    function automatic logic load_use(input stim_t ex, input stim_t id);
        logic [4:0] d;
        d = dest_of(ex);
        return ex.mem_read && d != 0 &&
               ((id.uses_rs && id.rs == d) || (id.uses_rt && id.rt == d));
    endfunction

    function automatic logic [2:0] fwd_sel(input logic uses, input logic [4:0] r, input stim_t s);
        if (!uses || r == 0) return 3'b000;
        if (s.ex_wr && s.ex_rd == r) return 3'b010;
        if (s.mem_wr && s.mem_rd == r) return 3'b001;
        return 3'b000;
    endfunction

    function automatic exp_t predict(input stim_t ex, input stim_t id, input int nb);
        exp_t e;
        e.data1      = ex.rs_data;
        e.data2      = ex.alu_src ? ex.imm : ex.rt_data;
        e.alu        = ex.alu;
        e.fwd_rs     = fwd_sel(ex.uses_rs, ex.rs, id);
        e.fwd_rt     = ex.alu_src ? 3'b000 : fwd_sel(ex.uses_rt, ex.rt, id);
        e.store      = ex.rt_data;
        e.wreg       = dest_of(ex);
        e.reg_write  = ex.reg_write;
        e.mem_read   = ex.mem_read;
        e.mem_write  = ex.mem_write;
        e.mem_to_reg = ex.mem_to_reg;
        e.stall      = load_use(ex, id);
        e.cnt        = 16'(nb);
        return e;
    endfunction

    task automatic apply(input stim_t s);
        rst_i = s.rst; Flush_i = s.flush;
        RsData_i = s.rs_data; RtData_i = s.rt_data; Imm_i = s.imm;
        Rs_i = s.rs; Rt_i = s.rt; Rd_i = s.rd;
        UsesRs_i = s.uses_rs; UsesRt_i = s.uses_rt; ALUCtrl_i = s.alu;
        ALUSrc_i = s.alu_src; RegDst_i = s.reg_dst; RegWrite_i = s.reg_write;
        MemRead_i = s.mem_read; MemWrite_i = s.mem_write; MemtoReg_i = s.mem_to_reg;
        ExRegWrite_i = s.ex_wr; ExRd_i = s.ex_rd;
        MemRegWrite_i = s.mem_wr; MemRd_i = s.mem_rd;
    endtask

    // One clock: the model absorbs the edge, then new inputs go out with their expectation.
    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        if (cur.rst) begin
            in_ex = '0; bubbles = 0;
        end else if (cur.flush || load_use(in_ex, cur)) begin
            in_ex = '0;
            if (bubbles < 65535) bubbles++;
        end else begin
            in_ex = cur;
            in_ex.rst = 0; in_ex.flush = 0;
            in_ex.ex_wr = 0; in_ex.ex_rd = 0; in_ex.mem_wr = 0; in_ex.mem_rd = 0;
        end
        cur = s;
        apply(s);
        sb_q.push_back(predict(in_ex, cur, bubbles));
        cycle++;
    endtask

    function automatic stim_t ins(input logic [4:0] rs, rt, rd, input logic urs, urt,
                                  input logic src, dst, wr, mrd, mwr, m2r,
                                  input logic [31:0] imm);
        stim_t s;
        s = '0;
        s.rs = rs; s.rt = rt; s.rd = rd; s.uses_rs = urs; s.uses_rt = urt;
        s.alu_src = src; s.reg_dst = dst; s.reg_write = wr;
        s.mem_read = mrd; s.mem_write = mwr; s.mem_to_reg = m2r; s.imm = imm;
        s.alu = 3'b010;
        s.rs_data = $urandom; s.rt_data = $urandom;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s = ins(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), $urandom);
        s.alu    = 3'($urandom);
        s.flush  = ($urandom_range(0, 15) == 0);
        s.rst    = ($urandom_range(0, 63) == 0);
        s.ex_wr  = 1'($urandom);
        s.ex_rd  = 5'($urandom_range(0, 7));
        s.mem_wr = 1'($urandom);
        s.mem_rd = 5'($urandom_range(0, 7));
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cycle %0d %s: got %h expected %h", cycle, name, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("data1",     data1_o,     e.data1);
            chk("data2",     data2_o,     e.data2);
            chk("alu_ctrl",  32'(ALUCtrl_o),   32'(e.alu));
            chk("fwd_rs",    32'(ForwardRs_o), 32'(e.fwd_rs));
            chk("fwd_rt",    32'(ForwardRt_o), 32'(e.fwd_rt));
            chk("store",     StoreData_o, e.store);
            chk("write_reg", 32'(WriteReg_o),  32'(e.wreg));
            chk("ctrl", 32'({RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o}),
                        32'({e.reg_write, e.mem_read, e.mem_write, e.mem_to_reg}));
            chk("stall",     32'(Stall_o),     32'(e.stall));
            chk("bubbles",   32'(BubbleCnt_o), 32'(e.cnt));
        end
    end

    initial begin
        stim_t s;
        in_ex = '0; bubbles = 0;
        cur = '0; cur.rst = 1;
        apply(cur);
        step(cur);
        step('0);

        // add $3,$1,$2 then add $4,$3,$5 with EX writing $3
        step(ins(1, 2, 3, 1, 1, 0, 1, 1, 0, 0, 0, 0));
        s = ins(3, 5, 4, 1, 1, 0, 1, 1, 0, 0, 0, 0);
        s.ex_wr = 1; s.ex_rd = 3;
        step(s);
        s = '0; s.ex_wr = 1; s.ex_rd = 3; s.mem_wr = 1; s.mem_rd = 3;
        step(s);
        s = ins(0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
        step(s);
        step('0);

        // lw $2,0($1) followed by add $4,$2,$2: one stall, then the add is re-presented
        step(ins(1, 2, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0));
        s = ins(2, 2, 4, 1, 1, 0, 1, 1, 0, 0, 0, 0);
        step(s);
        step(s);
        step('0);

        // addi $5,$3,7 with EX writing $3 and MEM writing $5
        step(ins(3, 5, 0, 1, 0, 1, 0, 1, 0, 0, 0, 32'd7));
        s = '0; s.ex_wr = 1; s.ex_rd = 3; s.mem_wr = 1; s.mem_rd = 5;
        step(s);

        // load-use hazard and flush on the same edge, then reset mid-stream
        step(ins(1, 2, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0));
        s = ins(2, 2, 4, 1, 1, 0, 1, 1, 0, 0, 0, 0);
        s.flush = 1;
        step(s);
        step(ins(4, 6, 7, 1, 1, 0, 1, 1, 0, 0, 0, 0));
        s = rnd(); s.rst = 1;
        step(s);
        step(rnd());

        for (int i = 0; i < 2000; i++) step(rnd());

        // push the bubble counter past its ceiling
        s = '0; s.rst = 1;
        step(s);
        s = '0; s.flush = 1;
        for (int i = 0; i < 65540; i++) step(s);
        step(ins(1, 2, 3, 1, 1, 0, 1, 1, 0, 0, 0, 0));
        step('0);
        for (int i = 0; i < 200; i++) step(rnd());

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_forward.md
ID_EX_FORWARD -- requirements
Module: id_ex_forward

Interface
REQ-001 The block SHALL expose these ports (name  direction  width  meaning), clock and reset first; one clock, clk_i, and reset rst_i, which is synchronous and active-high:
- clk_i  in  1  pipeline clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- RsData_i, RtData_i, Imm_i  in  32  ID register-file reads, sign-extended immediate
- Rs_i, Rt_i, Rd_i  in  5  ID register numbers
- UsesRs_i, UsesRt_i  in  1  ID instruction reads Rs / Rt
- ALUCtrl_i  in  3  ALU op code
- ALUSrc_i, RegDst_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i  in  1  ID control
- Flush_i  in  1  squash ID instruction (taken branch/jump)
- ExRegWrite_i, ExRd_i  in  1/5  EX/MEM-stage writer
- MemRegWrite_i, MemRd_i  in  1/5  MEM/WB-stage writer
- data1_o, data2_o  out  32  ALU operands
- ALUCtrl_o  out  3  registered ALU op
- ForwardRs_o, ForwardRt_o  out  3  forward select to ALU
- StoreData_o  out  32  registered RtData for stores
- WriteReg_o  out  5  destination register
- RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o  out  1  registered control
- Stall_o  out  1  hold PC and IF/ID this cycle
- BubbleCnt_o  out  16  inserted-bubble count
REQ-002 Parameter: none.

Function
REQ-003 On each rising edge without stall/flush, ID/EX SHALL capture all *_i ID fields; outputs are those registers, latency 1 cycle.
REQ-004 data2_o SHALL equal registered Imm when registered ALUSrc=1, else registered RtData; data1_o SHALL equal registered RsData.
REQ-005 WriteReg_o SHALL equal registered Rd when RegDst=1, else registered Rt.
REQ-006 Forward codes: 3'b010 = EX/MEM result, 3'b001 = MEM/WB result, 3'b000 = none; bit 2 always 0.
REQ-007 ForwardRs_o SHALL be 010 when ExRegWrite_i, ExRd_i!=0, ExRd_i==registered Rs, registered UsesRs; else 001 when same test holds on MemRegWrite_i/MemRd_i; else 000 (combinational from registers and current inputs).
REQ-008 ForwardRt_o SHALL follow REQ-007 for Rt and UsesRt, but SHALL be 000 whenever registered ALUSrc=1.
REQ-009 EX priority over MEM when both match; register 0 never forwarded.
REQ-010 Stall_o SHALL be 1 combinationally when registered MemRead=1, WriteReg_o!=0, and WriteReg_o equals Rs_i (with UsesRs_i) or Rt_i (with UsesRt_i); else 0.
REQ-011 On an edge with Stall_o=1 or Flush_i=1, ID/EX SHALL load a bubble: all control bits 0, ALUCtrl 000, register numbers 0, data 0.
REQ-012 Stall and Flush simultaneously SHALL insert exactly one bubble.
REQ-013 BubbleCnt_o SHALL increment by 1 per bubble of REQ-011 and saturate at 16'hFFFF.

Reset
REQ-014 rst_i=1 at an edge SHALL clear all ID/EX registers (bubble) and BubbleCnt_o to 0; reset dominates stall/flush; reset bubbles are not counted.
REQ-015 After reset, all outputs SHALL be 0, ForwardRs_o/ForwardRt_o 000 and Stall_o 0 until a load enters ID/EX.

Structure
REQ-016 Forward code constants (NONE/EX/MEM) and ALU op codes SHALL live in a shared include file used by this block and the ALU.
REQ-017 Forward compare logic SHALL be a combinational sub-module forward_unit, instantiated twice (Rs, Rt).

Verification
REQ-018 add $3,$1,$2 then add $4,$3,$5 (ExRegWrite_i=1, ExRd_i=3) -> ForwardRs_o=010, ForwardRt_o=000.
REQ-019 ExRd_i=3 and MemRd_i=3, both writes enabled, Rs=3 -> ForwardRs_o=010; ExRd_i=0, MemRd_i=0, Rs=0 -> 000.
REQ-020 lw $2,0($1) in ID/EX, ID add $4,$2,$2 -> Stall_o=1 one cycle, next ID/EX control all 0, BubbleCnt_o 0->1.
REQ-021 addi $5,$3,7 (ALUSrc=1) with ExRd_i=3, MemRd_i=5 -> data2_o=32'd7, ForwardRt_o=000, ForwardRs_o=010.
REQ-022 Flush_i=1 with Stall_o=1 same edge -> one bubble, BubbleCnt_o +1; rst_i=1 mid-stream -> all outputs 0 next cycle, BubbleCnt_o=0.
REQ-023 Force 65536 bubbles -> BubbleCnt_o holds 16'hFFFF.
